// File: rtl/store_uart_tx.sv
// rtl/store_uart_tx.sv - store-port byte FIFO draining through an 8N1 UART transmitter
//
// Ports:
//   clk        rising-edge clock shared with the core
//   areset     synchronous active-high reset
//   WE         store strobe; one push per cycle while high
//   data_in    core store data; only [7:0] is queued
//   tx         registered UART serial line, idles high
//   busy       frame in flight or bytes still queued
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   fifo_count FIFO occupancy, 0..FIFO_DEPTH
//   drop_cnt   writes lost to a full FIFO, saturating at 255

module store_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              WE,
    input  logic [31:0]       data_in,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W  = CNT_W - 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [7:0]         drop_q;

    logic               pop, push, drop_inc, baud_end;

    // Only the low byte of the store data is transmitted.
    logic unused_hi;
    assign unused_hi = ^data_in[31:8];

    assign pop      = (state_q == IDLE) && (count_q != '0);
    // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
    assign push     = WE && ((count_q != DEPTH_C) || pop);
    assign drop_inc = WE && !push && (drop_q != 8'hFF);
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = mem[rd_ptr];
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // tx is driven from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_inc) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (!areset && push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_store_uart_tx.sv
// tb/tb_store_uart_tx.sv - directed bench for store_uart_tx at 4 and 64 clocks per bit

module tb_store_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, we4, tx4, busy4, full4;
    logic [31:0] d4;
    logic [3:0]  cnt4;
    logic [7:0]  drop4;

    logic        rst64, we64, tx64, busy64, full64;
    logic [31:0] d64;
    logic [3:0]  cnt64;
    logic [7:0]  drop64;

    store_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .areset(rst4), .WE(we4), .data_in(d4), .tx(tx4), .busy(busy4),
        .fifo_full(full4), .fifo_count(cnt4), .drop_cnt(drop4)
    );

    store_uart_tx #(.CLKS_PER_BIT(64), .FIFO_DEPTH(8), .CNT_W(4)) dut64 (
        .clk(clk), .areset(rst64), .WE(we64), .data_in(d64), .tx(tx64), .busy(busy64),
        .fifo_full(full64), .fifo_count(cnt64), .drop_cnt(drop64)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rx_q[$];
    time         rx_t[$];
    int          frame_err = 0;

    // Independent 8N1 receiver on the 4-clocks-per-bit line, sampling mid-bit on negedges.
    initial begin
        logic [7:0] b;
        time        t0;
        forever begin
            @(negedge clk);
            if (tx4 === 1'b0) begin
                t0 = $time;
                b  = 8'd0;
                for (int j = 0; j < 8; j++) begin
                    repeat ((j == 0) ? 5 : 4) @(negedge clk);
                    b[j] = tx4;
                end
                repeat (4) @(negedge clk);
                if (tx4 !== 1'b1) frame_err++;
                rx_q.push_back(b);
                rx_t.push_back(t0);
                repeat (2) @(negedge clk);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (rx_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        check(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic wait_idle4(input string tag);
        int b;
        b = 2000;
        while ((busy4 !== 1'b0 || tx4 !== 1'b1) && b > 0) begin
            tick();
            b--;
        end
        check(tag, 64'({busy4, tx4}), 64'(2'b01));
    endtask

    initial begin
        logic [39:0] obs;
        logic        saw_low;

        rst4 = 1'b1; we4 = 1'b0; d4 = '0;
        rst64 = 1'b1; we64 = 1'b0; d64 = '0;
        repeat (3) tick();
        check("reset_tx",    64'(tx4),    64'(1));
        check("reset_busy",  64'(busy4),  64'(0));
        check("reset_full",  64'(full4),  64'(0));
        check("reset_count", 64'(cnt4),   64'(0));
        check("reset_drop",  64'(drop4),  64'(0));
        check("reset64_tx_busy_count", 64'({tx64, busy64, full64, cnt64, drop64}), 64'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
        rst4 = 1'b0; rst64 = 1'b0;
        tick();

        // Single byte 0xA5: exact waveform from e1 through e40, then idle.
        rx_q.delete(); rx_t.delete();
        we4 = 1'b1; d4 = 32'h0000_00A5;
        tick();
        we4 = 1'b0;
        check("a5_busy_after_e0",  64'(busy4), 64'(1));
        check("a5_count_after_e0", 64'(cnt4),  64'(1));
        for (int k = 0; k < 40; k++) begin
            tick();
            obs[k] = tx4;
        end
        check("a5_waveform", 64'(obs), 64'(40'hFF0F00F0F0));
        check("a5_busy_at_e40", 64'(busy4), 64'(1));
        tick();
        check("a5_busy_at_e41", 64'(busy4), 64'(0));
        check("a5_tx_idle",     64'(tx4),   64'(1));
        check("a5_rx_count",    64'(rx_q.size()), 64'(1));
        check("a5_rx_byte",     64'((rx_q.size() > 0) ? rx_q[0] : 8'hxx), 64'(8'hA5));

        // Upper store bits are ignored.
        rx_q.delete();
        we4 = 1'b1; d4 = 32'hDEAD_BE3C;
        tick();
        we4 = 1'b0;
        wait_rx(1, 60, "upper_rx_count");
        check("upper_rx_byte", 64'((rx_q.size() > 0) ? rx_q[0] : 8'hxx), 64'(8'h3C));
        wait_idle4("upper_idle");

        // Ten back-to-back writes into an 8-deep FIFO: 0x09 is dropped.
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            we4 = 1'b1; d4 = 32'(i);
            tick();
            if (i == 8) begin
                check("burst_full_after_9th",  64'(full4), 64'(1));
                check("burst_count_after_9th", 64'(cnt4),  64'(8));
            end
        end
        we4 = 1'b0;
        check("burst_drop",  64'(drop4), 64'(1));
        check("burst_count", 64'(cnt4),  64'(8));
        wait_rx(9, 9 * 41 + 60, "burst_rx_count");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("burst_rx_byte%0d", i), 64'((rx_q.size() > i) ? rx_q[i] : 8'hxx), 64'(i));
        end
        wait_idle4("burst_idle");
        check("burst_drained", 64'(cnt4), 64'(0));

        // Two consecutive writes: start bits 41 cycles apart.
        rx_q.delete(); rx_t.delete();
        we4 = 1'b1; d4 = 32'h55;
        tick();
        d4 = 32'h0F;
        tick();
        we4 = 1'b0;
        wait_rx(2, 150, "b2b_rx_count");
        check("b2b_byte0", 64'((rx_q.size() > 0) ? rx_q[0] : 8'hxx), 64'(8'h55));
        check("b2b_byte1", 64'((rx_q.size() > 1) ? rx_q[1] : 8'hxx), 64'(8'h0F));
        check("b2b_spacing", 64'((rx_t.size() > 1) ? (rx_t[1] - rx_t[0]) : 0), 64'(410));
        check("framing", 64'(frame_err), 64'(0));
        wait_idle4("b2b_idle");

        // Reset during data bit 3 with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            we4 = 1'b1; d4 = 32'h10 + 32'(i);
            tick();
        end
        we4 = 1'b0;
        repeat (15) tick();
        check("rst_mid_count_before", 64'(cnt4),  64'(3));
        check("rst_mid_busy_before",  64'(busy4), 64'(1));
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("rst_mid_tx",    64'(tx4),   64'(1));
        check("rst_mid_busy",  64'(busy4), 64'(0));
        check("rst_mid_count", 64'(cnt4),  64'(0));
        repeat (50) tick();
        rx_q.delete();
        frame_err = 0;
        saw_low = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (tx4 !== 1'b1) saw_low = 1'b1;
        end
        check("rst_mid_no_tx_low", 64'(saw_low), 64'(0));
        check("rst_mid_no_frames", 64'(rx_q.size()), 64'(0));

        // Drop counter saturation at 64 clocks per bit, FIFO held full mid-frame.
        for (int i = 0; i < 9; i++) begin
            we64 = 1'b1; d64 = 32'h80 + 32'(i);
            tick();
        end
        check("sat_count_full", 64'(cnt64),  64'(8));
        check("sat_drop_zero",  64'(drop64), 64'(0));
        repeat (200) tick();
        check("sat_drop_200", 64'(drop64), 64'(200));
        repeat (55) tick();
        check("sat_drop_255", 64'(drop64), 64'(255));
        repeat (45) tick();
        we64 = 1'b0;
        check("sat_drop_hold", 64'(drop64), 64'(255));
        check("sat_count_hold", 64'(cnt64), 64'(8));
        check("sat_full_hold",  64'(full64), 64'(1));
        check("sat_midframe_busy", 64'(busy64), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
